// File: rtl/bus_pkg.sv
// Shared definitions for the bus retry controller.
// FSM encoding, counter widths and saturation helper.
package bus_pkg;

    localparam int ERR_COUNT_W = 8;
    localparam int RETRY_W     = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        ABORT = 3'd3,
        RESP  = 3'd4
    } state_e;

    function automatic logic [ERR_COUNT_W-1:0] sat_inc(
        input logic [ERR_COUNT_W-1:0] v
    );
        return (&v) ? v : v + ERR_COUNT_W'(1);
    endfunction

endpackage

// File: rtl/bus_retry_ctrl.sv
// Single-command bus master with bounded retry on watchdog timeout.
// All outputs are registered; one command in flight at a time.
module bus_retry_ctrl
    import bus_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int MAX_RETRY = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [ADDR_W-1:0]      cmd_addr,
    output logic                   bus_req,
    output logic [ADDR_W-1:0]      bus_addr,
    input  logic                   bus_ack,
    input  logic [DATA_W-1:0]      bus_rdata,
    output logic                   start_transaction,
    output logic                   complete_transaction,
    input  logic                   timeout_error,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_W-1:0]      rsp_data,
    output logic                   rsp_err,
    output logic [ERR_COUNT_W-1:0] err_count
);

    localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);

    state_e                   state_q;
    logic [RETRY_W-1:0]       retry_q;
    logic                     cmd_ready_q;
    logic                     bus_req_q;
    logic [ADDR_W-1:0]        bus_addr_q;
    logic                     start_q;
    logic                     complete_q;
    logic                     rsp_valid_q;
    logic [DATA_W-1:0]        rsp_data_q;
    logic                     rsp_err_q;
    logic [ERR_COUNT_W-1:0]   err_count_q;

    // Control FSM; every output is set on the transition into its state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            retry_q     <= '0;
            cmd_ready_q <= 1'b1;
            bus_req_q   <= 1'b0;
            bus_addr_q  <= '0;
            start_q     <= 1'b0;
            complete_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            start_q    <= 1'b0;
            complete_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        bus_addr_q  <= cmd_addr;
                        retry_q     <= '0;
                        cmd_ready_q <= 1'b0;
                        bus_req_q   <= 1'b1;
                        start_q     <= 1'b1;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    // Ack wins over a coincident timeout.
                    if (bus_ack) begin
                        rsp_data_q  <= bus_rdata;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        bus_req_q   <= 1'b0;
                        complete_q  <= 1'b1;
                        state_q     <= RESP;
                    end else if (timeout_error) begin
                        bus_req_q  <= 1'b0;
                        complete_q <= 1'b1;
                        state_q    <= ABORT;
                    end
                end
                ABORT: begin
                    if (retry_q < RETRY_LIM) begin
                        retry_q   <= retry_q + RETRY_W'(1);
                        bus_req_q <= 1'b1;
                        start_q   <= 1'b1;
                        state_q   <= ISSUE;
                    end else begin
                        rsp_err_q   <= 1'b1;
                        rsp_data_q  <= '0;
                        rsp_valid_q <= 1'b1;
                        err_count_q <= sat_inc(err_count_q);
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cmd_ready_q <= 1'b1;
                    bus_req_q   <= 1'b0;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready            = cmd_ready_q;
    assign bus_req              = bus_req_q;
    assign bus_addr             = bus_addr_q;
    assign start_transaction    = start_q;
    assign complete_transaction = complete_q;
    assign rsp_valid            = rsp_valid_q;
    assign rsp_data             = rsp_data_q;
    assign rsp_err              = rsp_err_q;
    assign err_count            = err_count_q;

endmodule

// File: tb/tb_bus_retry_ctrl.sv
// Scoreboard bench for bus_retry_ctrl.
// Bus/watchdog model driven from a per-command plan.
module tb_bus_retry_ctrl;
    localparam int AW   = 16;
    localparam int DW   = 32;
    localparam int MAXR = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic          bus_req;
    logic [AW-1:0] bus_addr;
    logic          bus_ack = 1'b0;
    logic [DW-1:0] bus_rdata = '0;
    logic          start_transaction;
    logic          complete_transaction;
    logic          timeout_error = 1'b0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic [7:0]    err_count;

    bus_retry_ctrl #(.ADDR_W(AW), .DATA_W(DW), .MAX_RETRY(MAXR)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr),
        .bus_req(bus_req), .bus_addr(bus_addr),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .start_transaction(start_transaction),
        .complete_transaction(complete_transaction),
        .timeout_error(timeout_error),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        logic [7:0]    ecnt;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_err = 0;
    int n_start = 0;
    int n_cpl = 0;
    int n_rsp = 0;
    int m_ecnt = 0;

    int            p_fails = 0;
    int            p_ack_dly = 1;
    int            p_to_dly = 1;
    logic [DW-1:0] p_rdata = '0;
    bit            p_both = 0;
    int            att = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bus + watchdog model: answers each attempt start per the plan.
    initial begin
        int  d;
        bit  is_to;
        bit  hit_rst;
        forever begin
            @(negedge clk);
            if (!reset && start_transaction) begin
                is_to = (att < p_fails);
                d = is_to ? p_to_dly : p_ack_dly;
                att++;
                hit_rst = 0;
                for (int k = 0; k < d; k++) begin
                    @(negedge clk);
                    if (reset) begin
                        hit_rst = 1;
                        break;
                    end
                end
                if (!hit_rst) begin
                    if (is_to) begin
                        timeout_error = 1'b1;
                    end else begin
                        bus_ack = 1'b1;
                        bus_rdata = p_rdata;
                        timeout_error = p_both;
                    end
                    @(negedge clk);
                    bus_ack = 1'b0;
                    timeout_error = 1'b0;
                    bus_rdata = '0;
                end
            end
        end
    end

    // Output monitor: pulse counting and scoreboard pop on handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            chk("start_cpl_overlap",
                64'(start_transaction & complete_transaction), 64'd0);
            if (start_transaction) n_start++;
            if (complete_transaction) n_cpl++;
            if (rsp_valid && rsp_ready) begin
                chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("rsp_data", 64'(rsp_data), 64'(e.data));
                    chk("rsp_err", 64'(rsp_err), 64'(e.err));
                    chk("err_count", 64'(err_count), 64'(e.ecnt));
                end
                n_rsp++;
            end
        end
    end

    task automatic do_cmd(input logic [AW-1:0] addr, input int fails,
                          input int ack_dly, input int to_dly,
                          input logic [DW-1:0] rdata, input bit both,
                          input bit hold, input bit chk_lat);
        exp_t e;
        int s0, c0, r0, lat, exp_att;
        p_fails = fails;
        p_ack_dly = ack_dly;
        p_to_dly = to_dly;
        p_rdata = rdata;
        p_both = both;
        att = 0;
        e.err = (fails > MAXR);
        e.data = e.err ? '0 : rdata;
        if (e.err && m_ecnt < 255) m_ecnt++;
        e.ecnt = 8'(m_ecnt);
        exp_att = e.err ? MAXR + 1 : fails + 1;
        sb.push_back(e);
        s0 = n_start;
        c0 = n_cpl;
        r0 = n_rsp;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_addr = addr;
        rsp_ready = !hold;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("bus_addr", 64'(bus_addr), 64'(addr));
        chk("cmd_ready_busy", 64'(cmd_ready), 64'd0);
        chk("start_first", 64'(start_transaction), 64'd1);
        lat = 0;
        while (!rsp_valid && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
        chk("rsp_valid_seen", 64'(rsp_valid), 64'd1);
        if (chk_lat) chk("latency", 64'(lat), 64'd2);
        if (hold) begin
            for (int i = 0; i < 10; i++) begin
                chk("hold_valid", 64'(rsp_valid), 64'd1);
                chk("hold_data", 64'(rsp_data), 64'(e.data));
                chk("hold_err", 64'(rsp_err), 64'(e.err));
                chk("hold_cmd_ready", 64'(cmd_ready), 64'd0);
                @(negedge clk);
            end
            rsp_ready = 1'b1;
        end
        for (int k = 0; k < 20 && n_rsp == r0; k++) begin
            @(negedge clk);
            #1;
        end
        chk("rsp_handshake", 64'(n_rsp - r0), 64'd1);
        chk("start_pulses", 64'(n_start - s0), 64'(exp_att));
        chk("cpl_pulses", 64'(n_cpl - c0), 64'(exp_att));
        @(negedge clk);
        chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        chk("rsp_valid_drop", 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s0, c0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_bus_req", 64'(bus_req), 64'd0);
        chk("rst_start", 64'(start_transaction), 64'd0);
        chk("rst_cpl", 64'(complete_transaction), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_bus_addr", 64'(bus_addr), 64'd0);
        chk("rst_err_count", 64'(err_count), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        do_cmd(16'h0042, 0, 1, 1, 32'h0000_1111, 0, 0, 1);
        do_cmd(16'h1234, 0, 2, 1, 32'hDEAD_BEEF, 0, 0, 0);
        do_cmd(16'h2000, 1, 2, 3, 32'hCAFE_0001, 0, 0, 0);
        do_cmd(16'h3000, 99, 1, 2, 32'h5555_5555, 0, 0, 0);
        do_cmd(16'h4000, 0, 2, 1, 32'hA5A5_0042, 1, 0, 0);
        do_cmd(16'h5000, 2, 1, 1, 32'h0BAD_F00D, 0, 1, 0);
        do_cmd(16'h5001, 3, 3, 1, 32'h1357_9BDF, 0, 0, 0);

        // Stray ack/timeout while idle must be ignored.
        s0 = n_start;
        @(negedge clk);
        bus_ack = 1'b1;
        timeout_error = 1'b1;
        bus_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        bus_ack = 1'b0;
        timeout_error = 1'b0;
        bus_rdata = '0;
        @(negedge clk);
        chk("idle_ack_ready", 64'(cmd_ready), 64'd1);
        chk("idle_ack_rsp", 64'(rsp_valid), 64'd0);
        chk("idle_ack_start", 64'(n_start - s0), 64'd0);

        for (int i = 0; i < 6; i++) begin
            do_cmd(16'($urandom), $urandom_range(0, 5),
                   $urandom_range(1, 3), $urandom_range(1, 3),
                   $urandom, 0, 0, 0);
        end

        while (m_ecnt < 255) do_cmd(16'h7000, 99, 1, 1, 32'h1, 0, 0, 0);
        do_cmd(16'h7001, 99, 1, 1, 32'h2, 0, 0, 0);
        chk("sat_err_count", 64'(err_count), 64'd255);

        // Reset in the middle of WAIT.
        p_fails = 99;
        p_to_dly = 20;
        att = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_addr = 16'h8888;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("wait_bus_req", 64'(bus_req), 64'd1);
        c0 = n_cpl;
        reset = 1'b1;
        #1;
        chk("rstw_bus_req", 64'(bus_req), 64'd0);
        chk("rstw_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rstw_cpl", 64'(complete_transaction), 64'd0);
        chk("rstw_err_count", 64'(err_count), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        m_ecnt = 0;
        repeat (25) @(negedge clk);
        chk("rstw_no_cpl", 64'(n_cpl - c0), 64'd0);
        chk("rstw_no_rsp", 64'(rsp_valid), 64'd0);
        chk("rstw_sb_empty", 64'(sb.size()), 64'd0);
        do_cmd(16'h9999, 1, 1, 1, 32'h600D_600D, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/bus_retry_ctrl.md
BUS_RETRY_CTRL -- requirements
Module: bus_retry_ctrl

Interface
REQ-001 Parameter: ADDR_W, default 16, bus address width.
REQ-002 Parameter: DATA_W, default 32, read data width.
REQ-003 Parameter: MAX_RETRY, default 3, re-issues allowed after the first attempt; legal range 0-7.
REQ-004 clk  input  1  clock; all logic on its rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 cmd_valid  input  1  client command present.
REQ-007 cmd_ready  output  1  block can accept a command.
REQ-008 cmd_addr  input  ADDR_W  command address.
REQ-009 bus_req  output  1  bus request, held high until ack or abort.
REQ-010 bus_addr  output  ADDR_W  registered address of the current command.
REQ-011 bus_ack  input  1  single-cycle bus completion.
REQ-012 bus_rdata  input  DATA_W  data, valid with bus_ack.
REQ-013 start_transaction  output  1  one-cycle pulse to the watchdog at each attempt start.
REQ-014 complete_transaction  output  1  one-cycle pulse to the watchdog on ack or abort.
REQ-015 timeout_error  input  1  watchdog timeout indication.
REQ-016 rsp_valid  output  1  response available.
REQ-017 rsp_ready  input  1  client accepts the response.
REQ-018 rsp_data  output  DATA_W  captured bus_rdata; 0 on error.
REQ-019 rsp_err  output  1  command failed after all retries.
REQ-020 err_count  output  8  count of failed commands, saturating at 255.

Function
REQ-021 The FSM SHALL have the states IDLE, ISSUE, WAIT, ABORT and RESP.
REQ-022 IDLE: cmd_ready=1; cmd_valid captures cmd_addr into bus_addr, clears retry_cnt, and moves to ISSUE.
REQ-023 ISSUE: start_transaction=1 and bus_req=1 for exactly that cycle; move to WAIT.
REQ-024 WAIT: bus_req=1; on bus_ack, capture bus_rdata, pulse complete_transaction, clear rsp_err, and move to RESP.
REQ-025 WAIT: on timeout_error without bus_ack, deassert bus_req next cycle and move to ABORT.
REQ-026 A bus_ack and timeout_error in the same cycle SHALL resolve as success, with ack taking priority.
REQ-027 ABORT: one cycle with bus_req=0; pulse complete_transaction.
REQ-028 ABORT exit: if retry_cnt<MAX_RETRY, increment retry_cnt and go to ISSUE; otherwise set rsp_err=1, rsp_data=0, increment err_count (saturating), and go to RESP.
REQ-029 Total attempts per command SHALL be MAX_RETRY+1.
REQ-030 RESP: rsp_valid=1 with rsp_data and rsp_err stable until rsp_ready is sampled high; then go to IDLE.
REQ-031 cmd_ready SHALL be 0 in every state except IDLE; there is no command queuing.
REQ-032 bus_ack or timeout_error outside WAIT SHALL be ignored.
REQ-033 start_transaction and complete_transaction SHALL never be high in the same cycle.
REQ-034 Best-case command-to-response latency: cmd accepted at cycle N, ISSUE at N+1, ack at N+2, rsp_valid at N+3.

Reset
REQ-035 Reset SHALL force IDLE and drive these outputs to 0: bus_req, start_transaction, complete_transaction, rsp_valid, rsp_err, rsp_data, bus_addr, err_count; cmd_ready SHALL be 1.
REQ-036 Reset mid-transaction SHALL drop bus_req immediately with no complete_transaction pulse, and the in-flight command is lost.

Structure
REQ-037 The FSM state enum and the ERR_COUNT_W=8 constant SHALL reside in the shared package bus_pkg.
REQ-038 No sub-module SHALL be instantiated; the watchdog is instantiated alongside this block at the next level.

Verification
REQ-039 Command addr 0x1234, ack 2 cycles after start, rdata 0xDEADBEEF -> one start pulse, one complete pulse, rsp_data=0xDEADBEEF, rsp_err=0.
REQ-040 Timeout on attempt 1, ack on attempt 2 -> 2 start pulses, rsp_err=0, err_count unchanged.
REQ-041 MAX_RETRY=3 with a bus that never acks -> 4 start pulses, 4 complete pulses, rsp_err=1, rsp_data=0, err_count increments from 0 to 1.
REQ-042 bus_ack and timeout_error in the same WAIT cycle -> success response and no ABORT.
REQ-043 rsp_ready held low for 10 cycles -> rsp_valid and rsp_data stable throughout, cmd_ready=0.
REQ-044 err_count preset to 255 by 255 failed commands, then one more failure -> err_count stays at 255; reset asserted during WAIT -> bus_req=0 immediately, cmd_ready=1.
